// File: rtl/stim_pkg.sv
// Shared encodings, FSM state type, MISR polynomial and the pattern function
// for the stimulus pattern generator.
package stim_pkg;

  typedef logic [1:0] mode_t;
  localparam mode_t MODE_BIN  = 2'b00;
  localparam mode_t MODE_GRAY = 2'b01;
  localparam mode_t MODE_WALK = 2'b10;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // x^16 + x^14 + x^13 + x^11 + 1, right-shifting form
  localparam logic [15:0] MISR_POLY = 16'hB400;

  // Computed at full 17-bit width; callers truncate to their vector width.
  function automatic logic [16:0] pattern(input logic [16:0] idx, input mode_t m);
    case (m)
      MODE_GRAY: return idx ^ (idx >> 1);
      MODE_WALK: return 17'd1 << idx;
      default:   return idx;
    endcase
  endfunction

endpackage

// File: rtl/stim_misr.sv
// 16-bit multiple-input signature register compacting device responses.
module stim_misr
  import stim_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic [15:0] data_i,
  output logic [15:0] sig_o
);

  logic [15:0] sig_q, sig_d;

  always_comb begin
    sig_d = sig_q;
    if (clr_i) begin
      sig_d = '0;
    end else if (en_i) begin
      sig_d = (sig_q >> 1) ^ (sig_q[0] ? MISR_POLY : 16'h0000) ^ data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sig_q <= '0;
    else        sig_q <= sig_d;
  end

  assign sig_o = sig_q;

endmodule

// File: rtl/stim_pattern_gen.sv
// Stimulus pattern generator: binary / Gray / walking-one sequences, each vector
// held HOLD_CYC cycles. Define STIM_PATTERN_MISR_EN to compact resp into signature.
module stim_pattern_gen
  import stim_pkg::*;
#(
  parameter int WIDTH    = 3,
  parameter int HOLD_CYC = 100,
  parameter int RESP_W   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        mode,
  output logic [WIDTH-1:0]  vec,
  output logic              vec_strobe,
  output logic              busy,
  output logic              done,
  input  logic [RESP_W-1:0] resp,
  output logic [15:0]       signature
);

  localparam logic [15:0]    HOLD_LAST = 16'(HOLD_CYC - 1);
  localparam logic [WIDTH:0] LAST_SEQ  = {1'b0, {WIDTH{1'b1}}};
  localparam logic [WIDTH:0] LAST_WALK = (WIDTH + 1)'(WIDTH - 1);

  state_t         state_q, state_d;
  mode_t          mode_q, mode_d;
  logic [WIDTH:0] idx_q, idx_d;
  logic [15:0]    hold_q, hold_d;
  logic           accept, hold_end, last_vec;

  assign accept   = (state_q == ST_IDLE) && start && !abort;
  assign hold_end = (hold_q == HOLD_LAST);
  assign last_vec = (idx_q == ((mode_q == MODE_WALK) ? LAST_WALK : LAST_SEQ));

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_RUN;
          // 11 is folded onto binary at latch time
          mode_d  = (mode == MODE_GRAY || mode == MODE_WALK) ? mode : MODE_BIN;
          idx_d   = '0;
          hold_d  = '0;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
          idx_d   = '0;
          hold_d  = '0;
        end else if (hold_end) begin
          hold_d = '0;
          if (last_vec) begin
            state_d = ST_DONE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
        hold_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_BIN;
      idx_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
    end
  end

  assign busy       = (state_q == ST_RUN);
  assign done       = (state_q == ST_DONE);
  assign vec_strobe = busy && hold_end;
  assign vec        = busy ? WIDTH'(pattern(17'(idx_q), mode_q)) : '0;

`ifdef STIM_PATTERN_MISR_EN
  stim_misr u_misr (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (accept),
    .en_i   (vec_strobe),
    .data_i (16'(resp)),
    .sig_o  (signature)
  );
`else
  logic unused_resp;
  assign unused_resp = ^resp;
  assign signature   = '0;
`endif

endmodule

// File: doc/stim_pattern_gen.md
STIM_PATTERN_GEN -- requirements
Module: stim_pattern_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 3; stimulus vector width, legal range 1..16.
REQ-002 SHALL have parameter HOLD_CYC, default 100; clock cycles each vector is held, legal range 1..65535.
REQ-003 SHALL have parameter RESP_W, default 2; width of the response input from the device under test, legal range 1..16.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  begins a sequence when sampled high in IDLE.
REQ-007 abort  input  1  terminates a running sequence.
REQ-008 mode  input  2  pattern select: 00 binary count, 01 Gray, 10 walking-one, 11 treated as 00.
REQ-009 vec  output  WIDTH  stimulus vector driven to the device under test.
REQ-010 vec_strobe  output  1  one-cycle pulse in the final hold cycle of each vector (response sample point).
REQ-011 busy  output  1  high in RUN.
REQ-012 done  output  1  one-cycle pulse on normal completion.
REQ-013 resp  input  RESP_W  device-under-test response, sampled only when vec_strobe is high.
REQ-014 signature  output  16  response signature (see Configuration).

Function
REQ-015 The block SHALL be a three-state machine: IDLE, RUN, DONE.
REQ-016 IDLE -> RUN on start=1 and abort=0; the block SHALL latch mode and clear index and hold counter.
REQ-017 In RUN, vec SHALL equal pattern(index) starting the cycle after start is sampled (latency 1).
REQ-018 pattern(i) SHALL be i for binary, i^(i>>1) for Gray, and 1<<i for walking-one, truncated to WIDTH bits.
REQ-019 Sequence length SHALL be 2^WIDTH vectors for binary/Gray and WIDTH vectors for walking-one.
REQ-020 Each vector SHALL be held exactly HOLD_CYC cycles; vec_strobe SHALL be high only in the last of them.
REQ-021 After the last vector's final hold cycle the machine SHALL enter DONE: done=1, busy=0, vec=0 for one cycle, then enter IDLE.
REQ-022 start SHALL be ignored in RUN and DONE; mode changes after latching SHALL be ignored.
REQ-023 abort=1 in RUN SHALL force IDLE on the next edge: vec=0, busy=0, no done pulse; abort has priority over start and over completion in the same cycle.
REQ-024 Index and hold counters SHALL not wrap; index width SHALL be WIDTH+1 bits, so WIDTH=16 binary terminates after vector 0xFFFF.
REQ-025 In IDLE, vec, vec_strobe, busy and done SHALL all be 0.

Reset
REQ-026 rst_n=0 SHALL immediately force IDLE, vec=0, vec_strobe=0, busy=0, done=0, signature=0, all counters 0, including when asserted mid-sequence.
REQ-027 The first start after rst_n deasserts SHALL be honoured on the first rising edge at which it is sampled.

Configuration
REQ-028 Macro STIM_PATTERN_MISR_EN SHALL compile in a 16-bit MISR, polynomial x^16+x^14+x^13+x^11+1, cleared on accepted start, updated on each vec_strobe with resp zero-extended to 16 bits, held otherwise; signature SHALL expose its state.
REQ-029 Without STIM_PATTERN_MISR_EN, signature SHALL be tied to 0 and resp SHALL be unused; all other behaviour is identical.

Structure
REQ-030 Shared package stim_pkg SHALL hold the mode encoding constants, the FSM state typedef, and the MISR polynomial constant 16'hB400.
REQ-031 The MISR SHALL be a separate sub-module stim_misr, instantiated only under STIM_PATTERN_MISR_EN.

Verification
REQ-032 WIDTH=3, HOLD_CYC=2, mode=00, start pulse -> vec 0..7, each for 2 cycles; 8 strobes; done is high in cycle 17 after start.
REQ-033 WIDTH=3, mode=01 -> vec sequence 0,1,3,2,6,7,5,4; with mode=10 -> 1,2,4 then done.
REQ-034 abort while vec=5 -> next cycle vec=0, busy=0; done never pulses; a following start restarts at vec=0.
REQ-035 rst_n low mid-run (vec=3) -> all outputs 0 asynchronously; start held high through the run never restarts it.
REQ-036 STIM_PATTERN_MISR_EN with resp=0 -> signature=16'h0000 at done; with resp=vec[1:0] -> signature matches the bench's reference model.
